// File: rtl/count_monitor.sv
// count_monitor: watches an upstream free-running counter, classifies every
// step (inc / wrap / hold / jump), keeps wrap and stall statistics, flags a
// programmable match value and reports events over a 4-phase req/ack link.
module count_monitor #(
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned WRAP_W    = 8,
  parameter int unsigned STALL_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  count_in,
  input  logic [CNT_W-1:0]  match_val,
  input  logic              match_en,
  input  logic              evt_ack,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              overflow,
  output logic              stall,
  output logic              match_pulse,
  output logic              evt_req,
  output logic [1:0]        evt_code
);

  localparam int unsigned HOLD_W = $clog2(STALL_MAX + 1);
  localparam int unsigned EVT_N  = 4;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(STALL_MAX);

  // Event codes double as pending-bit indices.
  localparam logic [1:0] CODE_WRAP  = 2'd0;
  localparam logic [1:0] CODE_JUMP  = 2'd1;
  localparam logic [1:0] CODE_STALL = 2'd2;
  localparam logic [1:0] CODE_MATCH = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_ACKWAIT = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    prev;
  logic                prev_valid;
  logic [HOLD_W-1:0]   hold_run;
  logic [HOLD_W-1:0]   hold_run_nxt;
  logic [EVT_N-1:0]    pending;
  logic [EVT_N-1:0]    evt_set;
  logic [EVT_N-1:0]    evt_clr;
  logic [1:0]          code_nxt;
  logic                is_wrap;
  logic                is_hold;
  logic                is_jump;
  logic                stall_nxt;
  logic                match_hit;

  // Classify the current sample against the previous one.
  always_comb begin
    is_wrap = 1'b0;
    is_hold = 1'b0;
    is_jump = 1'b0;
    if (prev_valid) begin
      if ((prev == CNT_MAX) && (count_in == '0)) begin
        is_wrap = 1'b1;
      end else if (count_in == (prev + CNT_W'(1))) begin
        is_wrap = 1'b0;
      end else if (count_in == prev) begin
        is_hold = 1'b1;
      end else begin
        is_jump = 1'b1;
      end
    end
  end

  // Stall tracking, match detection and the set of events raised this cycle.
  always_comb begin
    hold_run_nxt = '0;
    if (is_hold) begin
      hold_run_nxt = (hold_run >= HOLD_SAT) ? HOLD_SAT : (hold_run + HOLD_W'(1));
    end
    stall_nxt = (hold_run_nxt >= HOLD_SAT);
    match_hit = match_en && prev_valid && !is_hold && (count_in == match_val);
    evt_set             = '0;
    evt_set[CODE_WRAP]  = is_wrap;
    evt_set[CODE_JUMP]  = is_jump;
    evt_set[CODE_STALL] = stall_nxt && !stall;
    evt_set[CODE_MATCH] = match_hit;
  end

  // Handshake next-state: pick the highest-priority pending event in IDLE.
  always_comb begin
    state_nxt = state;
    code_nxt  = evt_code;
    evt_clr   = '0;
    unique case (state)
      ST_IDLE: begin
        if (pending != '0) begin
          state_nxt = ST_REQ;
          if (pending[CODE_JUMP]) begin
            code_nxt = CODE_JUMP;
          end else if (pending[CODE_STALL]) begin
            code_nxt = CODE_STALL;
          end else if (pending[CODE_WRAP]) begin
            code_nxt = CODE_WRAP;
          end else begin
            code_nxt = CODE_MATCH;
          end
          evt_clr[code_nxt] = 1'b1;
        end
      end
      ST_REQ: begin
        if (evt_ack) begin
          state_nxt = ST_ACKWAIT;
        end
      end
      ST_ACKWAIT: begin
        if (!evt_ack) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sample history, statistics, pending events and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev        <= '0;
      prev_valid  <= 1'b0;
      hold_run    <= '0;
      wrap_count  <= '0;
      overflow    <= 1'b0;
      stall       <= 1'b0;
      match_pulse <= 1'b0;
      pending     <= '0;
      evt_req     <= 1'b0;
      evt_code    <= '0;
    end else begin
      prev        <= count_in;
      prev_valid  <= 1'b1;
      hold_run    <= hold_run_nxt;
      stall       <= stall_nxt;
      match_pulse <= match_hit;
      if (is_wrap) begin
        if (wrap_count == WRAP_MAX) begin
          overflow <= 1'b1;
        end else begin
          wrap_count <= wrap_count + WRAP_W'(1);
        end
      end
      // A fresh occurrence in the issuing cycle stays pending for a later request.
      pending  <= (pending & ~evt_clr) | evt_set;
      evt_req  <= (state_nxt == ST_REQ);
      evt_code <= code_nxt;
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: directed count sequences, expected event codes
// queued at stimulus time and popped by a monitor on each new request.
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] count_in;
  logic [3:0] match_val;
  logic       match_en;
  logic       evt_ack;
  logic [7:0] wrap_count;
  logic       overflow;
  logic       stall;
  logic       match_pulse;
  logic       evt_req;
  logic [1:0] evt_code;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] exp_q[$];
  logic       ack_auto = 1'b1;
  logic       ack_man  = 1'b0;
  logic       req_q    = 1'b0;

  count_monitor #(.CNT_W(4), .WRAP_W(8), .STALL_MAX(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .count_in    (count_in),
    .match_val   (match_val),
    .match_en    (match_en),
    .evt_ack     (evt_ack),
    .wrap_count  (wrap_count),
    .overflow    (overflow),
    .stall       (stall),
    .match_pulse (match_pulse),
    .evt_req     (evt_req),
    .evt_code    (evt_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive a new count before the edge, return just after the edge that samples it.
  task automatic step(input logic [3:0] c);
    @(negedge clk);
    count_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wrap_count"}, 32'(wrap_count), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_stall"}, 32'(stall), 0);
    check({tag, "_match_pulse"}, 32'(match_pulse), 0);
    check({tag, "_evt_req"}, 32'(evt_req), 0);
    check({tag, "_evt_code"}, 32'(evt_code), 0);
  endtask

  // Controller model plus scoreboard: ack responder and request checker.
  always @(negedge clk) begin
    if (ack_auto) begin
      if (evt_req) evt_ack = 1'b1;
      else if (evt_ack) evt_ack = 1'b0;
    end else begin
      evt_ack = ack_man;
    end
    if (evt_req && !req_q) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_req: got code %0d expected no request", evt_code);
      end else begin
        check("sb_evt_code", 32'(evt_code), 32'(exp_q.pop_front()));
      end
    end
    req_q = evt_req;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    count_in  = 4'd0;
    match_val = 4'd0;
    match_en  = 1'b0;
    evt_ack   = 1'b0;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    // Test 1: count 0..15 then wrap to 0.
    step(4'd0);
    check("t1_first_sample_req", 32'(evt_req), 0);
    for (int v = 1; v < 16; v++) begin
      step(4'(v));
      check("t1_inc_no_req", 32'(evt_req), 0);
    end
    check("t1_wrap_before", 32'(wrap_count), 0);
    step(4'd0);
    exp_q.push_back(2'd0);
    check("t1_wrap_count", 32'(wrap_count), 1);
    check("t1_overflow", 32'(overflow), 0);
    step(4'd1);
    check("t1_req", 32'(evt_req), 1);
    check("t1_code", 32'(evt_code), 0);

    // Test 2: upstream reset 5 -> 0 is a jump.
    for (int v = 2; v < 6; v++) step(4'(v));
    step(4'd0);
    exp_q.push_back(2'd1);
    check("t2_wrap_count", 32'(wrap_count), 1);

    // Test 3: hold at 7 for six samples.
    for (int v = 1; v < 8; v++) step(4'(v));
    for (int h = 1; h <= 5; h++) begin
      step(4'd7);
      if (h == 4) exp_q.push_back(2'd2);
      check("t3_stall", 32'(stall), (h >= 4) ? 1 : 0);
    end
    step(4'd8);
    check("t3_stall_fall", 32'(stall), 0);

    // Test 4: match on 9, then hold at 9.
    match_val = 4'd9;
    match_en  = 1'b1;
    step(4'd9);
    exp_q.push_back(2'd3);
    check("t4_match_pulse", 32'(match_pulse), 1);
    step(4'd9);
    check("t4_match_pulse_hold", 32'(match_pulse), 0);
    for (int v = 10; v < 16; v++) step(4'(v));

    // Test 5: wrap and match at 0 together, ack driven by hand.
    check("t5_idle_req", 32'(evt_req), 0);
    check("t5_idle_ack", 32'(evt_ack), 0);
    ack_auto  = 1'b0;
    ack_man   = 1'b0;
    match_val = 4'd0;
    step(4'd0);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd3);
    match_en = 1'b0;
    check("t5_wrap_count", 32'(wrap_count), 2);
    check("t5_match_pulse", 32'(match_pulse), 1);
    step(4'd1);
    check("t5_req_wrap", 32'(evt_req), 1);
    check("t5_code_wrap", 32'(evt_code), 0);
    step(4'd2);
    check("t5_req_held", 32'(evt_req), 1);
    check("t5_code_held", 32'(evt_code), 0);
    ack_man = 1'b1;
    step(4'd3);
    check("t5_req_drop", 32'(evt_req), 0);
    ack_man = 1'b0;
    step(4'd4);
    check("t5_idle_gap", 32'(evt_req), 0);
    step(4'd5);
    check("t5_req_match", 32'(evt_req), 1);
    check("t5_code_match", 32'(evt_code), 3);
    ack_man = 1'b1;
    step(4'd6);
    ack_man = 1'b0;
    step(4'd7);
    ack_auto = 1'b1;

    // Test 6: saturate the wrap counter, then reset during a request.
    for (int v = 8; v < 16; v++) step(4'(v));
    for (int w = 0; w < 253; w++) begin
      step(4'd0);
      exp_q.push_back(2'd0);
      for (int v = 1; v < 16; v++) step(4'(v));
    end
    check("t6_wrap_sat", 32'(wrap_count), 255);
    check("t6_overflow_pre", 32'(overflow), 0);
    step(4'd0);
    exp_q.push_back(2'd0);
    check("t6_wrap_hold", 32'(wrap_count), 255);
    check("t6_overflow", 32'(overflow), 1);
    step(4'd1);
    check("t6_req_before_reset", 32'(evt_req), 1);
    reset = 1'b0;
    step(4'd2);
    check_all_zero("t6_mid_reset");
    reset = 1'b1;
    step(4'd9);
    check("t6_first_after_reset", 32'(evt_req), 0);
    for (int v = 10; v < 14; v++) begin
      step(4'(v));
      check("t6_quiet_req", 32'(evt_req), 0);
    end
    check("t6_wrap_after_reset", 32'(wrap_count), 0);
    check("t6_overflow_after_reset", 32'(overflow), 0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    check("sb_drain", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
